uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. Assembles each received frame into a 12-bit entry (byte, parity bit, three error flags) and commits it at frame end. Stores entries in a show-ahead FIFO for the register/DMA interface. Generates overrun, level-threshold and character-timeout status.

Parameters:
AW, 4, FIFO address width; depth = 2**AW entries
TO_W, 16, width of character-timeout counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
rx_en  in  1  receiver enable; low aborts any staged frame
fifo_clr  in  1  synchronous flush of FIFO, staging, and flags
rx_vld_p  in  1  receiver byte-valid pulse
rx_byte  in  8  receiver byte
rx_parity  in  1  receiver parity/9th bit; stable from frame end until next start
parity_err_p  in  1  receiver parity-error pulse
stop_err_p  in  1  receiver stop (framing) error pulse
noise_p  in  1  OR of receiver start/data/parity/stop noise pulses
rx_state  in  3  receiver state; 0 = idle, 4 = stop
rd_pop  in  1  consumer pop strobe, one entry per cycle
ovr_clr  in  1  clears overrun
rx_thresh  in  AW+1  threshold level; 0 disables
timeout_val  in  TO_W  timeout in clk cycles; 0 disables
rd_data  out  8  head entry byte
rd_parity  out  1  head entry parity bit
rd_perr  out  1  head entry parity error
rd_ferr  out  1  head entry framing error
rd_nerr  out  1  head entry noise flag
empty  out  1  FIFO empty
full  out  1  FIFO full
level  out  AW+1  entry count, 0..2**AW
overrun  out  1  sticky: frame dropped because FIFO was full
thresh_irq  out  1  level >= rx_thresh with rx_thresh != 0
timeout_irq  out  1  character timeout, level signal

Behaviour:
- Reset values: empty=1, full=0, level=0, overrun=0, thresh_irq=0, timeout_irq=0; pointers, staging and flags cleared. rd_data fields are don't-care while empty.
- Staging:
  - rx_vld_p captures rx_byte, sets pending, and clears the stage flags perr/ferr/nerr.
  - While pending, parity_err_p, stop_err_p and noise_p OR into the stage flags.
  - rx_vld_p while pending (no stop seen) overwrites the stage.
- Commit:
  - Occurs in the cycle where pending=1, the previous rx_state is 4, and the current rx_state is 0.
  - The entry uses rx_parity sampled in that cycle. pending clears.
  - Same-cycle error pulses are included in the committed entry.
- Abort: rx_en low clears pending with no commit and no flag change. FIFO contents are kept.
- FIFO:
  - Show-ahead: rd_* reflects the head entry combinationally from the stored entry, with no read latency.
  - rd_pop when empty is ignored.
  - Commit when full drops the entry and sets overrun.
  - Commit and pop in the same cycle while full: both execute and level stays at 2**AW; overrun is not set.
  - Commit and pop in the same cycle while empty: the write executes and the pop is ignored; level becomes 1.
  - Pointers are AW bits wide and wrap modulo depth.
  - level updates in the cycle after a commit or pop.
- overrun: cleared by ovr_clr or fifo_clr. A set event in the same cycle as a clear wins.
- fifo_clr: pointers, level and pending go to 0; overrun, timeout counter and timeout_irq are cleared. Takes priority over commit and pop in the same cycle.
- thresh_irq: registered; follows the level compare one cycle after level changes.
- Timeout:
  - to_cnt clears on commit, pop, fifo_clr, when empty, or when rx_state != 0.
  - Otherwise to_cnt increments, saturating.
  - timeout_irq sets when to_cnt == timeout_val-1 and timeout_val != 0.
  - timeout_irq clears on pop, commit, or fifo_clr.

Test Plan:
- Single frame: rx_vld_p with 0x5A, rx_parity=1, then rx_state 4->0 -> next cycle empty=0, level=1, rd_data=0x5A, rd_parity=1, all error flags 0. rd_pop -> empty=1.
- Error flags: parity_err_p and noise_p pulse after rx_vld_p 0x33, stop_err_p in the commit cycle -> head entry 0x33 with rd_perr=1, rd_ferr=1, rd_nerr=1. The following clean frame has all flags 0.
- Fill/overrun (AW=4):
  - Commit 17 frames 0x00..0x10 -> full=1, level=16, overrun=1. Popping returns 0x00..0x0F in order.
  - Commit plus pop in the same cycle while full -> level stays 16, overrun unchanged.
- Abort: rx_vld_p 0xA5, then rx_en low before stop -> no commit, level unchanged.
- Threshold/timeout: rx_thresh=3, commit 3 frames -> thresh_irq=1 one cycle after level=3. timeout_val=100 with idle rx_state -> timeout_irq=1 exactly 100 cycles after the last commit; pop clears it.
- fifo_clr asserted with level=5 and overrun=1, plus a simultaneous commit -> next cycle level=0, empty=1, overrun=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: stages one frame, commits 12-bit entries
// into a show-ahead FIFO, and produces overrun, threshold and character-timeout status.
module uart_rx_fifo #(
  parameter int AW   = 4,
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rx_en,
  input  logic            fifo_clr,
  input  logic            rx_vld_p,
  input  logic [7:0]      rx_byte,
  input  logic            rx_parity,
  input  logic            parity_err_p,
  input  logic            stop_err_p,
  input  logic            noise_p,
  input  logic [2:0]      rx_state,
  input  logic            rd_pop,
  input  logic            ovr_clr,
  input  logic [AW:0]     rx_thresh,
  input  logic [TO_W-1:0] timeout_val,
  output logic [7:0]      rd_data,
  output logic            rd_parity,
  output logic            rd_perr,
  output logic            rd_ferr,
  output logic            rd_nerr,
  output logic            empty,
  output logic            full,
  output logic [AW:0]     level,
  output logic            overrun,
  output logic            thresh_irq,
  output logic            timeout_irq
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_STOP  = 3'd4;

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [2:0]      rx_state_p1;
  logic            pending;
  logic [7:0]      stg_byte;
  logic            stg_perr, stg_ferr, stg_nerr;
  logic            commit, pop_eff, wr_en, ovr_set, to_run;
  logic [11:0]     entry;
  logic [11:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [TO_W-1:0] to_cnt;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign commit  = pending && rx_en && !fifo_clr &&
                   (rx_state_p1 == ST_STOP) && (rx_state == ST_IDLE);
  assign pop_eff = rd_pop && !empty && !fifo_clr;
  assign wr_en   = commit && (!full || pop_eff);
  assign ovr_set = commit && full && !pop_eff;
  assign to_run  = !empty && (rx_state == ST_IDLE);
  // Same-cycle error pulses belong to the frame being committed
  assign entry   = {stg_nerr | noise_p, stg_ferr | stop_err_p, stg_perr | parity_err_p,
                    rx_parity, stg_byte};

  // Stage p0: frame staging
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_p1 <= ST_IDLE;
      pending     <= 1'b0;
      stg_byte    <= '0;
      stg_perr    <= 1'b0;
      stg_ferr    <= 1'b0;
      stg_nerr    <= 1'b0;
    end else begin
      rx_state_p1 <= rx_state;
      if (fifo_clr || !rx_en) begin
        pending <= 1'b0;
      end else if (rx_vld_p) begin
        pending  <= 1'b1;
        stg_byte <= rx_byte;
        stg_perr <= 1'b0;
        stg_ferr <= 1'b0;
        stg_nerr <= 1'b0;
      end else if (commit) begin
        pending <= 1'b0;
      end else if (pending) begin
        stg_perr <= stg_perr | parity_err_p;
        stg_ferr <= stg_ferr | stop_err_p;
        stg_nerr <= stg_nerr | noise_p;
      end
    end
  end

  // Stage p1: FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else if (fifo_clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop_eff)      level <= level + 1'b1;
      else if (pop_eff && !wr_en) level <= level - 1'b1;
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign {rd_nerr, rd_ferr, rd_perr, rd_parity, rd_data} = mem[rd_ptr];

  // Stage p2: status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      thresh_irq  <= 1'b0;
      to_cnt      <= '0;
      timeout_irq <= 1'b0;
    end else begin
      thresh_irq <= (rx_thresh != '0) && (level >= rx_thresh);
      if (fifo_clr || commit || pop_eff || !to_run) to_cnt <= '0;
      else                                          to_cnt <= sat_inc(to_cnt);
      if (fifo_clr || commit || pop_eff)
        timeout_irq <= 1'b0;
      else if (to_run && (timeout_val != '0) && (to_cnt == timeout_val - 1'b1))
        timeout_irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-level model.
module tb_uart_rx_fifo;
  localparam int AW    = 4;
  localparam int TO_W  = 16;
  localparam int DEPTH = 2 ** AW;

  logic            clk, rstn, rx_en, fifo_clr, rx_vld_p, rx_parity;
  logic [7:0]      rx_byte;
  logic            parity_err_p, stop_err_p, noise_p, rd_pop, ovr_clr;
  logic [2:0]      rx_state;
  logic [AW:0]     rx_thresh;
  logic [TO_W-1:0] timeout_val;
  logic [7:0]      rd_data;
  logic            rd_parity, rd_perr, rd_ferr, rd_nerr, empty, full;
  logic [AW:0]     level;
  logic            overrun, thresh_irq, timeout_irq;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] q[$];
  bit          m_ovr;

  uart_rx_fifo #(.AW(AW), .TO_W(TO_W)) dut (
    .clk(clk), .rstn(rstn), .rx_en(rx_en), .fifo_clr(fifo_clr),
    .rx_vld_p(rx_vld_p), .rx_byte(rx_byte), .rx_parity(rx_parity),
    .parity_err_p(parity_err_p), .stop_err_p(stop_err_p), .noise_p(noise_p),
    .rx_state(rx_state), .rd_pop(rd_pop), .ovr_clr(ovr_clr),
    .rx_thresh(rx_thresh), .timeout_val(timeout_val),
    .rd_data(rd_data), .rd_parity(rd_parity), .rd_perr(rd_perr),
    .rd_ferr(rd_ferr), .rd_nerr(rd_nerr), .empty(empty), .full(full),
    .level(level), .overrun(overrun), .thresh_irq(thresh_irq),
    .timeout_irq(timeout_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, " level"}, 32'(level), 32'(q.size()));
    chk({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, " full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
    if (q.size() > 0)
      chk({tag, " head"}, 32'({rd_nerr, rd_ferr, rd_perr, rd_parity, rd_data}), 32'(q[0]));
  endtask

  // One receiver frame: byte valid, stop state with mid-frame pulses, then idle (commit cycle)
  task automatic frame(input logic [7:0] b, input logic par, input logic pe, input logic fe,
                       input logic ne, input logic pop, input logic clr);
    logic [11:0] e;
    rx_vld_p = 1'b1; rx_byte = b; rx_state = 3'd2;
    tick();
    rx_vld_p = 1'b0; parity_err_p = pe; noise_p = ne; rx_state = 3'd4;
    rx_byte = 8'($urandom);
    tick();
    parity_err_p = 1'b0; noise_p = 1'b0; rx_state = 3'd0; rx_parity = par;
    stop_err_p = fe; rd_pop = pop; fifo_clr = clr;
    tick();
    stop_err_p = 1'b0; rd_pop = 1'b0; fifo_clr = 1'b0;
    e = {ne, fe, pe, par, b};
    if (clr) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (q.size() == DEPTH) m_ovr = 1'b1;
      else q.push_back(e);
    end
  endtask

  task automatic pop1();
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  initial begin
    rstn = 1'b0; rx_en = 1'b1; fifo_clr = 1'b0; rx_vld_p = 1'b0; rx_byte = '0;
    rx_parity = 1'b0; parity_err_p = 1'b0; stop_err_p = 1'b0; noise_p = 1'b0;
    rx_state = 3'd0; rd_pop = 1'b0; ovr_clr = 1'b0; rx_thresh = '0; timeout_val = '0;
    m_ovr = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    check_state("reset");
    chk("reset thresh_irq", 32'(thresh_irq), 32'd0);
    chk("reset timeout_irq", 32'(timeout_irq), 32'd0);

    frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("single");
    chk("single data", 32'(rd_data), 32'h5A);
    pop1();
    check_state("single pop");
    pop1();
    check_state("pop empty");

    frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_state("errflags");
    chk("errflags bits", 32'({rd_perr, rd_ferr, rd_nerr}), 32'h7);
    frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    pop1();
    check_state("clean after err");
    chk("clean flags", 32'({rd_perr, rd_ferr, rd_nerr}), 32'h0);
    pop1();

    for (int i = 0; i <= DEPTH; i++)
      frame(8'(i), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("fill");
    chk("fill overrun", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
    check_state("ovr_clr");
    frame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("full commit+pop");
    chk("full commit+pop level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      check_state("drain");
      pop1();
    end
    check_state("drained");

    frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_state("commit+pop empty");
    pop1();

    rx_vld_p = 1'b1; rx_byte = 8'hA5; rx_state = 3'd2;
    tick();
    rx_vld_p = 1'b0; rx_state = 3'd4; rx_en = 1'b0;
    tick();
    rx_en = 1'b1; rx_state = 3'd0;
    tick(); tick();
    check_state("abort");

    rx_thresh = 5'd3; timeout_val = 16'd100;
    for (int i = 0; i < 3; i++)
      frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("thresh");
    chk("thresh lag", 32'(thresh_irq), 32'd0);
    tick();
    chk("thresh set", 32'(thresh_irq), 32'd1);
    chk("timeout early", 32'(timeout_irq), 32'd0);
    repeat (98) tick();
    chk("timeout at 99", 32'(timeout_irq), 32'd0);
    tick();
    chk("timeout at 100", 32'(timeout_irq), 32'd1);
    pop1();
    chk("timeout pop clr", 32'(timeout_irq), 32'd0);
    check_state("timeout pop");
    timeout_val = '0; rx_thresh = '0;

    while (q.size() < DEPTH)
      frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (q.size() > 5) pop1();
    check_state("pre clr");
    frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_state("fifo_clr");

    rx_thresh = 5'(1 + $urandom_range(0, DEPTH - 1));
    for (int it = 0; it < 120; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 3) == 0), 1'b0);
      end else if (r <= 7) begin
        pop1();
      end else if (r == 8) begin
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        m_ovr = 1'b0;
      end else begin
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        q.delete();
        m_ovr = 1'b0;
      end
      tick();
      check_state("rand");
      chk("rand thresh", 32'(thresh_irq), 32'(q.size() >= int'(rx_thresh)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
